cache_port_arbiter: RTL and testbench

- Shares the single processor-side port of the cache controller between two requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Latches the winning request, issues a one-cycle procRead/procWrite pulse to the cache controller and waits for its completion strobe.
- Returns read data and a one-cycle ack to the winner.
- Round-robin fairness, plus a watchdog that flags a hung cache transaction.

---
 rtl/cache_port_arbiter_pkg.sv | 26 ++
 rtl/cache_port_arbiter_rr_pick.sv | 31 +++
 rtl/cache_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_cache_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_port_arbiter_pkg.sv
// ============================================================================
// Module : cache_port_arbiter_pkg
// Brief  : Shared state encodings and helpers for the cache port arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cache_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    // Clock period shared with simulation environments.
    localparam int CP = 10;

    function automatic logic [1:0] port_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cache_port_arbiter_rr_pick.sv
// ============================================================================
// Module : arb_rr_pick
// Brief  : Two-way round-robin pick with a one-cycle mask on the last winner.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module arb_rr_pick (
    input  logic [1:0] valid,
    input  logic       last,
    input  logic [1:0] mask,
    output logic       grant_valid,
    output logic       grant_id
);

    logic [1:0] w_eligible;

    always_comb begin
        w_eligible  = valid & ~mask;
        grant_valid = |w_eligible;
        grant_id    = 1'b0;
        if (w_eligible == 2'b11) begin
            grant_id = ~last;
        end else if (w_eligible[1]) begin
            grant_id = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cache_port_arbiter.sv
// ============================================================================
// Module : cache_port_arbiter
// Brief  : Shares the cache controller processor port between two requesters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cache_port_arbiter
    import cache_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_read,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ack,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_read,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ack,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              procRead,
    output logic              procWrite,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [DATA_W-1:0] cache_wdata,
    input  logic [DATA_W-1:0] cache_rdata,
    input  logic              cache_done,
    output logic              busy,
    output logic              timeout_err
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        r_state;
    logic              r_last;
    logic [1:0]        r_mask;
    logic              r_win;
    logic              r_op_read;
    logic [CNT_W-1:0]  r_cnt;

    logic [1:0]        w_valid;
    logic              w_grant_valid;
    logic              w_grant_id;
    logic              w_grant_read;
    logic [DATA_W-1:0] w_capture;

    assign w_valid      = {req1_read | req1_write, req0_read | req0_write};
    assign w_grant_read = w_grant_id ? req1_read : req0_read;
    // Writes return zero so the requester never sees stale cache data.
    assign w_capture    = r_op_read ? cache_rdata : '0;

    arb_rr_pick u_pick (
        .valid       (w_valid),
        .last        (r_last),
        .mask        (r_mask),
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ARB_IDLE;
            r_last      <= 1'b1;
            r_mask      <= 2'b00;
            r_win       <= 1'b0;
            r_op_read   <= 1'b0;
            r_cnt       <= '0;
            req0_ack    <= 1'b0;
            req1_ack    <= 1'b0;
            req0_rdata  <= '0;
            req1_rdata  <= '0;
            procRead    <= 1'b0;
            procWrite   <= 1'b0;
            cache_addr  <= '0;
            cache_wdata <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            procRead  <= 1'b0;
            procWrite <= 1'b0;
            req0_ack  <= 1'b0;
            req1_ack  <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    r_mask <= 2'b00;
                    if (w_grant_valid) begin
                        r_win       <= w_grant_id;
                        r_op_read   <= w_grant_read;
                        cache_addr  <= w_grant_id ? req1_addr : req0_addr;
                        cache_wdata <= w_grant_id ? req1_wdata : req0_wdata;
                        procRead    <= w_grant_read;
                        procWrite   <= ~w_grant_read;
                        busy        <= 1'b1;
                        r_state     <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (cache_done || (r_cnt == C_CNT_LAST)) begin
                        if (!cache_done) begin
                            timeout_err <= 1'b1;
                        end
                        if (r_win) begin
                            req1_rdata <= cache_done ? w_capture : '0;
                            req1_ack   <= 1'b1;
                        end else begin
                            req0_rdata <= cache_done ? w_capture : '0;
                            req0_ack   <= 1'b1;
                        end
                        r_state <= ARB_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ARB_RESP: begin
                    r_last  <= r_win;
                    r_mask  <= port_onehot(r_win);
                    busy    <= 1'b0;
                    r_state <= ARB_IDLE;
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cache_port_arbiter.sv
// ============================================================================
// Module : tb_cache_port_arbiter
// Brief  : Randomized self-checking bench with a transaction-timeline model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cache_port_arbiter;
    import cache_port_arbiter_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_read  [2];
    logic          req_write [2];
    logic [AW-1:0] req_addr  [2];
    logic [DW-1:0] req_wdata [2];
    logic          req0_ack, req1_ack;
    logic [DW-1:0] req0_rdata, req1_rdata;
    logic          procRead, procWrite;
    logic [AW-1:0] cache_addr;
    logic [DW-1:0] cache_wdata, cache_rdata;
    logic          cache_done, busy, timeout_err;

    always #(CP/2) clk = ~clk;

    cache_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req0_read(req_read[0]), .req0_write(req_write[0]),
        .req0_addr(req_addr[0]), .req0_wdata(req_wdata[0]),
        .req0_ack(req0_ack), .req0_rdata(req0_rdata),
        .req1_read(req_read[1]), .req1_write(req_write[1]),
        .req1_addr(req_addr[1]), .req1_wdata(req_wdata[1]),
        .req1_ack(req1_ack), .req1_rdata(req1_rdata),
        .procRead(procRead), .procWrite(procWrite),
        .cache_addr(cache_addr), .cache_wdata(cache_wdata),
        .cache_rdata(cache_rdata), .cache_done(cache_done),
        .busy(busy), .timeout_err(timeout_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: each transaction is a timeline (grant, done, ack) fixed at grant time.
    int            cyc;
    bit            has_txn;
    int            t_grant, t_done, t_ack;
    int            w_port;
    bit            w_rd, w_to;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata, w_cv, w_rdata;
    bit            err_m;
    logic [DW-1:0] rd_m [2];
    bit            granted [2];

    int            p_req [2];
    int            p_hold [2];
    int            p_to;
    bit            spur;
    int            force_dly;
    bit            force_cv_en;
    logic [DW-1:0] force_cv;
    bit            force_done_now;

    task automatic step();
        bit v0, v1;
        int w, dly, k, last_port;
        bit exp_pr, exp_pw, exp_busy;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            if (has_txn && cyc == t_ack + 1 && w_port == p) begin
                if ($urandom_range(99) >= p_hold[p]) begin
                    req_read[p]  = 1'b0;
                    req_write[p] = 1'b0;
                end
                granted[p] = 1'b0;
            end else if (granted[p]) begin
                req_addr[p]  = AW'($urandom);
                req_wdata[p] = DW'($urandom);
            end else if (!(req_read[p] || req_write[p]) && $urandom_range(99) < p_req[p]) begin
                case ($urandom_range(2))
                    0:       begin req_read[p] = 1'b1; req_write[p] = 1'b0; end
                    1:       begin req_read[p] = 1'b0; req_write[p] = 1'b1; end
                    default: begin req_read[p] = 1'b1; req_write[p] = 1'b1; end
                endcase
                req_addr[p]  = AW'($urandom);
                req_wdata[p] = DW'($urandom);
            end
        end
        if (!has_txn || cyc > t_ack) begin
            v0 = (req_read[0] || req_write[0]) && !(has_txn && cyc == t_ack + 1 && w_port == 0);
            v1 = (req_read[1] || req_write[1]) && !(has_txn && cyc == t_ack + 1 && w_port == 1);
            if (v0 || v1) begin
                last_port = has_txn ? w_port : 1;
                if (v0 && v1) w = 1 - last_port;
                else          w = v0 ? 0 : 1;
                if (force_dly >= 0) begin
                    dly = force_dly;
                    force_dly = -1;
                end else if ($urandom_range(99) < p_to) dly = 0;
                else if ($urandom_range(9) == 0)     dly = TO;
                else                                  dly = $urandom_range(4, 1);
                w_cv = force_cv_en ? force_cv : DW'($urandom);
                force_cv_en = 1'b0;
                has_txn = 1'b1;
                w_port  = w;
                w_rd    = req_read[w];
                w_addr  = req_addr[w];
                w_wdata = req_wdata[w];
                granted[w] = 1'b1;
                t_grant = cyc;
                w_to    = (dly == 0);
                t_done  = w_to ? -1 : cyc + 1 + dly;
                t_ack   = w_to ? cyc + 2 + TO : t_done + 1;
                w_rdata = (w_to || !w_rd) ? '0 : w_cv;
            end
        end
        if (has_txn && cyc == t_done) begin
            cache_done  = 1'b1;
            cache_rdata = w_cv;
        end else begin
            cache_rdata = DW'($urandom);
            cache_done  = force_done_now ||
                          (spur && $urandom_range(7) == 0 &&
                           !(has_txn && cyc >= t_grant + 2 && cyc < t_ack));
        end
        force_done_now = 1'b0;

        @(posedge clk);
        #1;
        k = cyc + 1;
        exp_pr   = has_txn && k == t_grant + 1 && w_rd;
        exp_pw   = has_txn && k == t_grant + 1 && !w_rd;
        exp_busy = has_txn && k > t_grant && k <= t_ack;
        if (has_txn && k == t_ack) begin
            rd_m[w_port] = w_rdata;
            if (w_to) err_m = 1'b1;
        end
        check_eq("procRead", procRead, exp_pr);
        check_eq("procWrite", procWrite, exp_pw);
        check_eq("busy", busy, exp_busy);
        check_eq("req0_ack", req0_ack, has_txn && k == t_ack && w_port == 0);
        check_eq("req1_ack", req1_ack, has_txn && k == t_ack && w_port == 1);
        check_eq("req0_rdata", req0_rdata, rd_m[0]);
        check_eq("req1_rdata", req1_rdata, rd_m[1]);
        check_eq("timeout_err", timeout_err, err_m);
        if (exp_busy) begin
            check_eq("cache_addr", cache_addr, w_addr);
            check_eq("cache_wdata", cache_wdata, w_wdata);
        end
        cyc++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        p_req  = '{0, 0};
        p_hold = '{0, 0};
        while (n < 300 && ((has_txn && cyc <= t_ack + 1) ||
               req_read[0] || req_write[0] || req_read[1] || req_write[1])) begin
            step();
            n++;
        end
        check_eq("drain_bound", n < 300, 1);
    endtask

    task automatic model_reset();
        has_txn = 1'b0;
        err_m   = 1'b0;
        rd_m    = '{'0, '0};
        granted = '{1'b0, 1'b0};
        for (int p = 0; p < 2; p++) begin
            req_read[p]  = 1'b0;
            req_write[p] = 1'b0;
            req_addr[p]  = '0;
            req_wdata[p] = '0;
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        cache_done = 1'b0;
        cache_rdata = '0;
        cyc = 0;
        t_grant = 0; t_done = -1; t_ack = 0; w_port = 0;
        p_req = '{0, 0}; p_hold = '{0, 0}; p_to = 0; spur = 1'b0;
        force_dly = -1; force_cv_en = 1'b0; force_cv = '0; force_done_now = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_procRead", procRead, 0);
        check_eq("rst_procWrite", procWrite, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ack0", req0_ack, 0);
        check_eq("rst_ack1", req1_ack, 0);
        check_eq("rst_rdata0", req0_rdata, 0);
        check_eq("rst_rdata1", req1_rdata, 0);
        check_eq("rst_timeout", timeout_err, 0);
        check_eq("rst_addr", cache_addr, 0);
        reset = 1'b0;

        // Single read on port 0.
        req_read[0] = 1'b1; req_addr[0] = 8'h12; req_wdata[0] = 8'h77;
        force_dly = 2; force_cv = 8'hA5; force_cv_en = 1'b1;
        repeat (8) step();
        check_eq("single_read_rdata", req0_rdata, 8'hA5);
        drain();

        // Write on port 1.
        req_write[1] = 1'b1; req_addr[1] = 8'h3C; req_wdata[1] = 8'h5A; force_dly = 3;
        repeat (8) step();
        check_eq("write_rdata_zero", req1_rdata, 0);
        drain();

        // Both ports held: service alternates.
        req_read[0] = 1'b1; req_read[1] = 1'b1;
        p_hold = '{100, 100};
        repeat (40) step();
        drain();

        // Port 0 alone holds over its ack.
        req_read[0] = 1'b1; p_hold = '{100, 0};
        repeat (20) step();
        drain();

        // Watchdog, then a good transaction with the flag still set.
        req_read[1] = 1'b1; force_dly = 0;
        repeat (TO + 8) step();
        check_eq("timeout_set", timeout_err, 1);
        check_eq("timeout_rdata", req1_rdata, 0);
        drain();
        req_read[0] = 1'b1; force_dly = 1;
        repeat (8) step();
        check_eq("timeout_sticky", timeout_err, 1);
        drain();

        // Random traffic with occasional hangs and stray done pulses.
        spur = 1'b1; p_to = 5;
        p_req = '{30, 30}; p_hold = '{25, 25};
        repeat (3000) step();
        drain();

        // Asynchronous reset in the middle of WAIT.
        spur = 1'b0;
        req_read[0] = 1'b1; force_dly = 0;
        n = 0;
        while (!(has_txn && cyc == t_grant + 5) && n < 100) begin
            step();
            n++;
        end
        check_eq("reach_wait", n < 100, 1);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_timeout", timeout_err, 0);
        check_eq("arst_rdata0", req0_rdata, 0);
        check_eq("arst_addr", cache_addr, 0);
        check_eq("arst_ack0", req0_ack, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc++;
        force_done_now = 1'b1;
        repeat (4) step();
        req_read[1] = 1'b1; req_addr[1] = 8'h44; force_dly = 1;
        repeat (8) step();
        drain();

        spur = 1'b1;
        p_req = '{40, 40}; p_hold = '{20, 20};
        repeat (800) step();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
